// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at the last cycle, restart whenever the owner clears.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter pulling bytes from a first-word-fall-through FIFO.
// Optional even parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_empty,
  input  logic                 tx_en,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  tx_state_e            state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 rd_q, rd_d;
  logic                 timer_clear;
  logic                 bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_done(bit_done)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE:   if (tx_en && !fifo_empty) state_d = SETTLE;
      SETTLE: begin
        state_d = START;
        shift_d = fifo_data;
        idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
      end
      START:  if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP: begin
        if (bit_done) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    timer_clear = (state_d != state_q);
    // SETTLE always leads to START, so the pop lands on the first START cycle.
    rd_d = (state_q == SETTLE);
    // tx is decoded from the upcoming state so the flop output tracks the state.
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd     = rd_q;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign frames_sent = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FWFT FIFO model, frame scoreboard, table + hand sequences.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int GAP = FB * C + 2;
  localparam int NV  = 6;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = '0;
  logic       fifo_rd, tx, busy;
  logic [1:0] frames_sent;

  fifo_uart_tx #(
    .CLKS_PER_BIT(C),
    .CNT_WIDTH   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .tx_en      (tx_en),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  frame_t     exp_q[$];
  logic [7:0] fifo_q[$];
  int         rd_cycles[$];
  frame_t     vec[NV];
  int         checks = 0, errors = 0;
  int         cyc = 0, pops = 0, popped = 0, fr = 0;
  logic       mon_en = 1'b1, mon_busy = 1'b0;
  logic [1:0] exp_cnt = '0;
  int         n, base;
  logic       seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    frame_t f;
    f.data = d;
    f.par  = ^d;
    @(negedge clk);
    fifo_q.push_back(d);
    exp_q.push_back(f);
  endtask

  task automatic push_vec(input frame_t f);
    @(negedge clk);
    fifo_q.push_back(f.data);
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && (exp_q.size() != 0 || fifo_q.size() != 0 || mon_busy || busy)) begin
      @(negedge clk);
      k++;
    end
    check("idle within budget", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    int k;
    k = 0;
    while (k < budget && fifo_rd !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("fifo_rd within budget", 32'(k < budget), 32'd1);
  endtask

  initial begin
    vec[0] = '{8'h00, 1'b0};
    vec[1] = '{8'hFF, 1'b0};
    vec[2] = '{8'h07, 1'b1};
    vec[3] = '{8'h03, 1'b0};
    vec[4] = '{8'h01, 1'b1};
    vec[5] = '{8'h5A, 1'b0};

    fork
      // Upstream FWFT FIFO: registered output, pops one cycle after fifo_rd.
      forever begin
        @(posedge clk);
        cyc++;
        #1;
        while (popped < pops) begin
          if (fifo_q.size() != 0) void'(fifo_q.pop_front());
          popped++;
        end
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) fifo_data = fifo_q[0];
      end
      // Pop sniffer.
      forever begin
        @(negedge clk);
        if (fifo_rd === 1'b1) begin
          pops++;
          rd_cycles.push_back(cyc);
        end
      end
      // Frame monitor: checks every bit period of each popped byte.
      forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
          exp_cnt = '0;
        end else if (fifo_rd === 1'b1 && mon_en) begin
          mon_busy = 1'b1;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected pop: got fifo_rd=1 expected no pending byte");
          end else begin
            frame_t     f;
            logic [10:0] b;
            f = exp_q.pop_front();
            fr++;
            b = '1;
            b[0] = 1'b0;
            b[8:1] = f.data;
`ifdef FIFO_UART_TX_PARITY_EN
            b[9] = f.par;
`endif
            for (int i = 0; i < FB; i++) begin
              logic [C-1:0] s;
              for (int c = 0; c < C; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                s[c] = tx;
                if (i == 0 && c == 1) check("fifo_rd one cycle", 32'(fifo_rd), 32'd0);
              end
              check($sformatf("frame%0d bit%0d", fr, i), 32'(s), 32'({C{b[i]}}));
            end
            @(negedge clk);
            exp_cnt = exp_cnt + 1'b1;
            check($sformatf("frame%0d frames_sent", fr), 32'(frames_sent), 32'(exp_cnt));
            check($sformatf("frame%0d busy after stop", fr), 32'(busy), 32'd0);
          end
          mon_busy = 1'b0;
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset fifo_rd", 32'(fifo_rd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frames_sent", 32'(frames_sent), 32'd0);
    reset = 1'b0;

    // Single byte with pop latency.
    tx_en = 1'b1;
    push_byte(8'hA5);
    @(negedge clk);
    check("A5 decision cycle idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("A5 settle busy", 32'(busy), 32'd1);
    check("A5 settle no pop", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    check("A5 pop two after decision", 32'(fifo_rd), 32'd1);
    wait_idle(100);
    check("A5 frames_sent", 32'(frames_sent), 32'd1);
    check("A5 pop count", 32'(pops), 32'd1);

    // Table: queued back-to-back, spacing checked from recorded pop cycles.
    rd_cycles.delete();
    base = pops;
    for (int i = 0; i < NV; i++) push_vec(vec[i]);
    wait_idle(NV * GAP + 50);
    check("table pops", 32'(pops - base), 32'(NV));
    for (int i = 1; i < NV && i < rd_cycles.size(); i++)
      check($sformatf("b2b spacing %0d", i), 32'(rd_cycles[i] - rd_cycles[i-1]), 32'(GAP));

    // tx_en dropped in DATA bit 3.
    push_byte(8'h3C);
    push_byte(8'hC3);
    wait_rd(20);
    repeat (17) @(negedge clk);
    tx_en = 1'b0;
    check("tx_en drop mid-frame busy", 32'(busy), 32'd1);
    n = 0;
    while (n < 100 && (mon_busy || busy)) begin
      @(negedge clk);
      n++;
    end
    check("frame completes after tx_en drop", 32'(n < 100), 32'd1);
    base = pops;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("no settle while tx_en low", 32'(seen), 32'd0);
    check("no pop while tx_en low", 32'(pops - base), 32'd0);
    check("byte held while tx_en low", 32'(fifo_q.size()), 32'd1);
    tx_en = 1'b1;
    wait_idle(100);

    // Reset in DATA bit 5.
    mon_en = 1'b0;
    @(negedge clk);
    fifo_q.push_back(8'h81);
    wait_rd(20);
    repeat (25) @(negedge clk);
    check("pre-reset data bit5", 32'(tx), 32'd0);
    base = pops;
    reset = 1'b1;
    @(negedge clk);
    check("mid reset tx", 32'(tx), 32'd1);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset frames_sent", 32'(frames_sent), 32'd0);
    check("mid reset fifo_rd", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("no pop after reset", 32'(pops - base), 32'd0);
    check("idle after reset", 32'(seen), 32'd0);
    mon_en = 1'b1;
    push_byte(8'h96);
    wait_idle(100);
    check("fresh frame counted", 32'(frames_sent), 32'd1);

    // Counter wrap with a 2-bit count.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push_vec(vec[i]);
    wait_idle(5 * GAP + 50);
    check("wrap frames_sent", 32'(frames_sent), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of frames_sent.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fifo_data  input  8  first-word-fall-through head byte from the upstream FIFO, registered there.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO holds no items.
REQ-007 SHALL have port tx_en  input  1  permits a new frame to start.
REQ-008 SHALL have port fifo_rd  output  1  one-cycle pop request to the FIFO, registered.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port frames_sent  output  CNT_WIDTH  count of completed frames, wraps to 0.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, START, DATA, PARITY, STOP.
REQ-013 IDLE SHALL go to SETTLE when tx_en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE with tx=1.
REQ-014 SETTLE SHALL last exactly 1 cycle, absorbing the FIFO's registered-output lag; at its end it SHALL latch fifo_data into the shift register and go to START.
REQ-015 fifo_rd SHALL be high for exactly the first START cycle and low in all other cycles; one pop per frame.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL shift out 8 bits LSB first, each for CLKS_PER_BIT cycles, with a 3-bit bit index.
REQ-018 PARITY SHALL exist only per REQ-027.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, increment frames_sent on its last cycle, then go to IDLE.
REQ-020 The bit timer SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change.
REQ-021 tx SHALL be driven from a register, glitch-free.
REQ-022 tx_en deassertion mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->SETTLE transition.
REQ-023 fifo_empty rising during SETTLE SHALL NOT cancel the frame, because the decision was made in IDLE.
REQ-024 Minimum frame-to-frame spacing SHALL be 10*CLKS_PER_BIT+2 cycles (no parity), comprising STOP->IDLE plus SETTLE.

Reset
REQ-025 On reset=1 at a clock edge, state SHALL go to IDLE, tx=1, fifo_rd=0, busy=0, frames_sent=0, and timer, index and shift register SHALL clear.
REQ-026 Reset mid-frame SHALL truncate the frame immediately (tx=1 next cycle), SHALL NOT count the frame, and SHALL NOT issue another pop.

Configuration
REQ-027 Macro FIFO_UART_TX_PARITY_EN: when defined, the PARITY state SHALL follow DATA and drive even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making the frame 11 bits; when undefined, DATA SHALL go directly to STOP and PARITY logic SHALL be absent.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state enum typedef and the constants DATA_BITS=8 and STOP_BITS=1.
REQ-029 The bit timer SHALL be a sub-module, uart_bit_timer (parameter CLKS_PER_BIT; inputs clk, reset, clear; output bit_done).

Verification (CLKS_PER_BIT=4, parity off unless noted)
REQ-030 Single byte: fifo_empty falls with fifo_data=8'hA5, tx_en=1 -> fifo_rd pulses once, 2 cycles after the IDLE decision; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frames_sent=1.
REQ-031 Back-to-back: bytes 8'h00 and 8'hFF, fifo_empty held low -> two frames, start edges exactly 42 cycles apart, two fifo_rd pulses, frames_sent=2.
REQ-032 Parity (macro defined): byte 8'h07 -> parity bit 1, frame 44 cycles; byte 8'h03 -> parity bit 0.
REQ-033 tx_en dropped during DATA bit 3 -> frame completes; no new SETTLE while tx_en=0 despite fifo_empty=0.
REQ-034 Reset asserted during DATA bit 5 -> tx=1 next cycle, busy=0, frames_sent=0, no fifo_rd; after release a fresh frame starts.
REQ-035 Counter wrap: CNT_WIDTH=2 with 5 frames -> frames_sent=1.
